// File: rtl/byte_word_assembler_if.sv
// rtl/byte_word_assembler_if.sv - byte stream in / assembled word out bundle for byte_word_assembler
//
// Purpose: groups the UART byte strobe, the arm/abort level and the word
// valid/ready handshake with its status outputs.
// Ports (signals):
//   enable, rx_ready, rx_data, word_ready          driven by the master side
//   word_out, word_valid, busy, end_of_stream,
//   err_timeout, err_overrun, word_count           driven by the assembler (slave)
interface byte_word_assembler_if #(
    parameter int DATA_W = 10,
    parameter int CNT_W  = 16
);
    logic              enable;
    logic              rx_ready;
    logic [7:0]        rx_data;
    logic [DATA_W-1:0] word_out;
    logic              word_valid;
    logic              word_ready;
    logic              busy;
    logic              end_of_stream;
    logic              err_timeout;
    logic              err_overrun;
    logic [CNT_W-1:0]  word_count;

    modport master (
        output enable, rx_ready, rx_data, word_ready,
        input  word_out, word_valid, busy, end_of_stream,
               err_timeout, err_overrun, word_count
    );

    modport slave (
        input  enable, rx_ready, rx_data, word_ready,
        output word_out, word_valid, busy, end_of_stream,
               err_timeout, err_overrun, word_count
    );
endinterface

// File: rtl/byte_word_assembler.sv
// rtl/byte_word_assembler.sv - gathers little-endian UART bytes into DATA_W-bit words
//
// Purpose: collects BYTES_PER_WORD bytes per word, presents the word on a
// valid/ready output, stops on an end-of-stream marker byte, discards stalled
// partial words after TIMEOUT_CYCLES idle cycles and flags dropped words.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      byte_word_assembler_if.slave (byte input, word output, status)
module byte_word_assembler #(
    parameter int         DATA_W         = 10,
    parameter logic [7:0] END_BYTE       = 8'hFF,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter int         CNT_W          = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    byte_word_assembler_if.slave bus
);
    localparam int BYTES_PER_WORD = (DATA_W + 7) / 8;
    localparam int IDX_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int ACC_BYTES      = (BYTES_PER_WORD > 1) ? BYTES_PER_WORD - 1 : 1;
    localparam int ACC_W          = 8 * ACC_BYTES;
    localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_END_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [TO_W-1:0]   tcnt_q, tcnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_to_q, err_to_d;
    logic              err_ov_q, err_ov_d;
    logic              store;
    logic [DATA_W-1:0] cand;

    // Earlier bytes are shifted in from the top, so once the final byte
    // arrives byte 0 sits in the least-significant position of acc_q.
    assign cand = (BYTES_PER_WORD == 1) ? DATA_W'(bus.rx_data)
                                        : DATA_W'({bus.rx_data, acc_q});

    assign store = bus.enable && bus.rx_ready && (state_q != S_END_HOLD);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tcnt_d   = tcnt_q;
        acc_d    = acc_q;
        word_d   = word_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        err_to_d = 1'b0;
        err_ov_d = 1'b0;

        if (valid_q && bus.word_ready) begin
            valid_d = 1'b0;
            cnt_d   = cnt_q + 1'b1;
        end

        case (state_q)
            S_END_HOLD: begin
                if (!bus.enable) begin
                    state_d = S_IDLE;
                end
            end
            S_COLLECT: begin
                if (!bus.enable) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    tcnt_d  = '0;
                end else if (!bus.rx_ready && idx_q != '0) begin
                    if (tcnt_q == TO_LAST) begin
                        err_to_d = 1'b1;
                        idx_d    = '0;
                        tcnt_d   = '0;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase

        if (store) begin
            tcnt_d  = '0;
            state_d = S_COLLECT;
            if (idx_q == LAST_IDX) begin
                idx_d = '0;
                if (bus.rx_data == END_BYTE) begin
                    state_d = S_END_HOLD;
                end else if (!valid_q || bus.word_ready) begin
                    // A same-cycle accept frees the register for the new word.
                    word_d  = cand;
                    valid_d = 1'b1;
                end else begin
                    err_ov_d = 1'b1;
                end
            end else begin
                acc_d = ACC_W'({bus.rx_data, acc_q} >> 8);
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            tcnt_q   <= '0;
            acc_q    <= '0;
            word_q   <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
            err_to_q <= 1'b0;
            err_ov_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tcnt_q   <= tcnt_d;
            acc_q    <= acc_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
            err_to_q <= err_to_d;
            err_ov_q <= err_ov_d;
        end
    end

    assign bus.word_out      = word_q;
    assign bus.word_valid    = valid_q;
    assign bus.word_count    = cnt_q;
    assign bus.err_timeout   = err_to_q;
    assign bus.err_overrun   = err_ov_q;
    assign bus.end_of_stream = (state_q == S_END_HOLD);
    assign bus.busy          = (state_q != S_IDLE) || valid_q;
endmodule

// File: tb/tb_byte_word_assembler.sv
// tb/tb_byte_word_assembler.sv - directed and randomized checks of byte_word_assembler against a queue model
module tb_byte_word_assembler;
    localparam int DATA_W = 10;
    localparam int CNT_W  = 16;
    localparam int T      = 16;
    localparam int BPW    = (DATA_W + 7) / 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    bit   done    = 1'b0;

    byte_word_assembler_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    byte_word_assembler #(
        .DATA_W(DATA_W),
        .END_BYTE(8'hFF),
        .TIMEOUT_CYCLES(T),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic strobe(input logic [7:0] b);
        bus.rx_ready = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: a queue of bytes of the word in progress, a pending
    // output word and three stream modes (0 idle, 1 collecting, 2 end hold).
    initial begin : compare
        logic [7:0]        partial[$];
        int                idle_run;
        bit                m_valid;
        logic [DATA_W-1:0] m_word;
        int                m_count;
        int                mode;
        bit                ev_to, ev_ov;
        bit                en, rxr, wr, rst;
        logic [7:0]        rxd;
        longint            w;
        idle_run = 0; m_valid = 0; m_word = '0; m_count = 0; mode = 0;
        while (!done) begin
            @(posedge clk);
            en = bus.enable; rxr = bus.rx_ready; rxd = bus.rx_data;
            wr = bus.word_ready; rst = reset_n;
            ev_to = 0; ev_ov = 0;
            if (!rst) begin
                partial.delete(); idle_run = 0; m_valid = 0; m_word = '0;
                m_count = 0; mode = 0;
            end else begin
                if (m_valid && wr) begin
                    m_valid = 0;
                    m_count = (m_count + 1) % (1 << CNT_W);
                end
                if (mode == 2) begin
                    if (!en) mode = 0;
                end else if (!en) begin
                    partial.delete(); idle_run = 0; mode = 0;
                end else if (rxr) begin
                    partial.push_back(rxd);
                    idle_run = 0;
                    mode = 1;
                    if (partial.size() == BPW) begin
                        if (rxd == 8'hFF) begin
                            mode = 2;
                        end else begin
                            w = 0;
                            for (int i = 0; i < BPW; i++) w += longint'(partial[i]) << (8 * i);
                            w = w % (longint'(1) << DATA_W);
                            if (!m_valid) begin
                                m_word  = DATA_W'(w);
                                m_valid = 1;
                            end else begin
                                ev_ov = 1;
                            end
                        end
                        partial.delete();
                    end
                end else if (partial.size() > 0) begin
                    idle_run++;
                    if (idle_run == T) begin
                        ev_to = 1; partial.delete(); idle_run = 0;
                    end
                end
            end
            #1;
            chk("m_word_valid", 32'(bus.word_valid), 32'(m_valid));
            if (m_valid) chk("m_word_out", 32'(bus.word_out), 32'(m_word));
            chk("m_word_count", 32'(bus.word_count), 32'(m_count));
            chk("m_busy", 32'(bus.busy), 32'(mode != 0 || m_valid));
            chk("m_end_of_stream", 32'(bus.end_of_stream), 32'(mode == 2));
            chk("m_err_timeout", 32'(bus.err_timeout), 32'(ev_to));
            chk("m_err_overrun", 32'(bus.err_overrun), 32'(ev_ov));
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : stim
        int quiet;
        quiet = 0;
        bus.enable = 1'b0; bus.rx_ready = 1'b0; bus.rx_data = 8'h00; bus.word_ready = 1'b0;
        #1;
        chk("rst_word_valid", 32'(bus.word_valid), 32'd0);
        chk("rst_word_out", 32'(bus.word_out), 32'd0);
        chk("rst_word_count", 32'(bus.word_count), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_eos", 32'(bus.end_of_stream), 32'd0);
        idle(2);
        reset_n = 1'b1;
        bus.enable = 1'b1;

        // basic word
        bus.word_ready = 1'b1;
        strobe(8'h34); strobe(8'h02);
        chk("basic_valid", 32'(bus.word_valid), 32'd1);
        chk("basic_word", 32'(bus.word_out), 32'h234);
        idle(1);
        chk("basic_count", 32'(bus.word_count), 32'd1);
        chk("basic_cleared", 32'(bus.word_valid), 32'd0);

        // truncation and backpressure
        bus.word_ready = 1'b0;
        strobe(8'hAA); strobe(8'hFE);
        for (int i = 0; i < 5; i++) begin
            chk("hold_word", 32'(bus.word_out), 32'h2AA);
            chk("hold_valid", 32'(bus.word_valid), 32'd1);
            idle(1);
        end
        bus.word_ready = 1'b1;
        idle(1);
        chk("bp_cleared", 32'(bus.word_valid), 32'd0);
        chk("bp_count", 32'(bus.word_count), 32'd2);

        // overrun, then completion coinciding with an accept
        bus.word_ready = 1'b0;
        strobe(8'h01); strobe(8'h00);
        chk("ov_first", 32'(bus.word_out), 32'h001);
        strobe(8'h02);
        chk("ov_not_yet", 32'(bus.err_overrun), 32'd0);
        strobe(8'h00);
        chk("ov_pulse", 32'(bus.err_overrun), 32'd1);
        chk("ov_kept", 32'(bus.word_out), 32'h001);
        idle(1);
        chk("ov_once", 32'(bus.err_overrun), 32'd0);
        strobe(8'h02);
        bus.word_ready = 1'b1;
        strobe(8'h00);
        chk("swap_word", 32'(bus.word_out), 32'h002);
        chk("swap_valid", 32'(bus.word_valid), 32'd1);
        chk("swap_no_ov", 32'(bus.err_overrun), 32'd0);
        chk("swap_count", 32'(bus.word_count), 32'd3);
        idle(1);
        chk("swap_count2", 32'(bus.word_count), 32'd4);
        bus.word_ready = 1'b0;

        // end-of-stream marker
        strobe(8'h00); strobe(8'hFF);
        chk("eos_no_word", 32'(bus.word_valid), 32'd0);
        chk("eos_set", 32'(bus.end_of_stream), 32'd1);
        strobe(8'h12); strobe(8'h34);
        chk("eos_ignore", 32'(bus.word_valid), 32'd0);
        chk("eos_held", 32'(bus.end_of_stream), 32'd1);
        bus.enable = 1'b0;
        idle(1);
        chk("eos_clear", 32'(bus.end_of_stream), 32'd0);
        chk("eos_idle", 32'(bus.busy), 32'd0);
        bus.enable = 1'b1;

        // timeout
        strobe(8'h55);
        idle(T - 1);
        chk("to_early", 32'(bus.err_timeout), 32'd0);
        idle(1);
        chk("to_pulse", 32'(bus.err_timeout), 32'd1);
        idle(1);
        chk("to_once", 32'(bus.err_timeout), 32'd0);
        strobe(8'h11); strobe(8'h01);
        chk("to_word", 32'(bus.word_out), 32'h111);
        bus.word_ready = 1'b1;
        idle(1);
        chk("to_count", 32'(bus.word_count), 32'd5);
        bus.word_ready = 1'b0;

        // abort by enable, then asynchronous reset with a pending word
        strobe(8'h99);
        bus.enable = 1'b0;
        idle(1);
        chk("abort_idle", 32'(bus.busy), 32'd0);
        bus.enable = 1'b1;
        strobe(8'h22); strobe(8'h03);
        chk("abort_word", 32'(bus.word_out), 32'h322);
        chk("abort_valid", 32'(bus.word_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.word_valid), 32'd0);
        chk("arst_count", 32'(bus.word_count), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            reset_n    = ($urandom_range(0, 999) >= 3);
            bus.enable = ($urandom_range(0, 99) >= 3);
            if (quiet > 0) begin
                quiet--;
                bus.rx_ready = 1'b0;
            end else begin
                if ($urandom_range(0, 99) < 3) quiet = $urandom_range(12, 24);
                bus.rx_ready = ($urandom_range(0, 99) < 45);
            end
            bus.rx_data    = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom);
            bus.word_ready = ($urandom_range(0, 99) < 40);
            @(negedge clk);
        end
        reset_n = 1'b1;
        bus.rx_ready = 1'b0;
        done = 1'b1;
        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
